// File: rtl/ifu_pkg.sv
// Shared definitions for the prefetching instruction fetch unit: default widths,
// the FIFO entry layout and the credit-counter width helper.
package ifu_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;

    // Counters must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus: redirect input, instruction-memory request/response channels
// and the decode-side output channel. master = fetch unit, slave = environment.
interface ifu_prefetch_if #(parameter int XLEN = ifu_pkg::XLEN_DEF);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; the head entry is presented directly from
// register storage so a push is visible on rdata the following cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0],
    parameter int  CW    = cnt_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              wdata,
    output T              rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Credit-based prefetching fetch unit with redirect flush and stale-response discard.
// Defining IFU_PERF_CNT_EN adds saturating fetched/discarded response counters.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = 4
) (
    input  logic clock,
    input  logic reset,
    ifu_prefetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count, pcq_count;
    logic            fifo_empty, fifo_full, pcq_empty, pcq_full;
    logic [XLEN-1:0] pcq_head;
    entry_t          push_entry, head_entry;
    logic            redirect, rsp, accept, discarding, push_rsp, pop_out;
    logic            unused_status;

    assign redirect   = bus.redirect_valid;
    assign rsp        = bus.imem_rsp_valid;
    assign discarding = (discard_q != '0);

    // Every request in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign bus.imem_req_valid = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C)
                                && !redirect && !reset;
    assign bus.imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    assign push_rsp         = rsp && !discarding && !redirect;
    assign push_entry.pc    = pcq_head;
    assign push_entry.instr = bus.imem_rsp_data;

    assign bus.out_valid = !fifo_empty && !redirect;
    assign bus.out_pc    = head_entry.pc;
    assign bus.out_instr = head_entry.instr;
    assign pop_out       = bus.out_valid && bus.out_ready;

    ifu_fifo #(.DEPTH(DEPTH), .T(entry_t), .CW(CW)) u_prefetch_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_rsp),
        .pop   (pop_out),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Addresses of live requests; responses being discarded have no entry here.
    ifu_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0]), .CW(CW)) u_pc_queue (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (rsp && !discarding),
        .flush (redirect),
        .wdata (bus.imem_req_addr),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    assign unused_status = ^{pcq_count, pcq_full, pcq_empty, fifo_full,
                             fetch_pc_q[1:0], bus.redirect_pc[1:0]};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
        if (redirect) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight is stale; outstanding already includes
            // any responses still pending discard, so this also covers back-to-back redirects.
            discard_d  = outstanding_q - CW'(rsp);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp && discarding) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_discarded_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            if (push_rsp && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (rsp && !push_rsp && (perf_discarded_q != '1)) begin
                perf_discarded_q <= perf_discarded_q + 32'd1;
            end
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: in-order memory model with configurable latency,
// pop monitor, one task per scenario.
module tb_ifu_prefetch;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ifu_prefetch_if #(.XLEN(32)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded;
`endif

    ifu_prefetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;
    int cyc;
    int inflight;
    int max_inflight;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: a request accepted at an edge answers mem_lat cycles later.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            cyc                <= 0;
            inflight           <= 0;
        end else begin
            cyc      <= cyc + 1;
            inflight <= inflight + ((bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0)
                        - (bus.imem_rsp_valid ? 1 : 0);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{bus.imem_req_addr, cyc + mem_lat - 1});
                acc_addr.push_back(bus.imem_req_addr);
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= instr_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            max_inflight <= 0;
        end else begin
            if (inflight > max_inflight) max_inflight <= inflight;
            if (bus.out_valid && bus.out_ready) begin
                got_pc.push_back(bus.out_pc);
                got_instr.push_back(bus.out_instr);
                $display("pop pc=%08h instr=%08h", bus.out_pc, bus.out_instr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        acc_addr.delete();
        got_pc.delete();
        got_instr.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL release_req_valid: got %b want 1", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL release_req_addr: got %h want 0", bus.imem_req_addr); end
    endtask

    task automatic test_stream();
        mem_lat = 1;
        do_reset();
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_first_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL stream_first_pc: got %h want 0", bus.out_pc); end
        n_cmp++; if (bus.out_instr !== instr_of(32'h0)) begin n_bad++; $display("FAIL stream_first_instr: got %h want %h", bus.out_instr, instr_of(32'h0)); end
        repeat (8) tick();
        n_cmp++; if (acc_addr.size() != 10) begin n_bad++; $display("FAIL stream_req_count: got %0d want 10", acc_addr.size()); end
        for (int i = 0; i < acc_addr.size(); i++) begin
            n_cmp++; if (acc_addr[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, acc_addr[i], 32'(4 * i)); end
        end
        n_cmp++; if (got_pc.size() != 8) begin n_bad++; $display("FAIL stream_pop_count: got %0d want 8", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            n_cmp++; if (got_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_pop_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        bus.out_ready = 1'b0;
        repeat (10) tick();
        n_cmp++; if (acc_addr.size() != DEPTH) begin n_bad++; $display("FAIL bp_accepts: got %0d want %0d", acc_addr.size(), DEPTH); end
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== 32'h10) begin n_bad++; $display("FAIL bp_pc_held: got %h want 00000010", bus.imem_req_addr); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head_pc: got %h want 0", bus.out_pc); end
        bus.out_ready = 1'b1;
        repeat (10) tick();
        n_cmp++; if (got_pc.size() != 10) begin n_bad++; $display("FAIL bp_pop_count: got %0d want 10", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            n_cmp++; if (got_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_pop_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4 * i)); end
        end
    endtask

    // Latency 3: redirect lands in the cycle the 0x8 response arrives while a
    // request would otherwise be accepted; 0xC is still in flight.
    task automatic test_redirect_latency();
        mem_lat = 3;
        do_reset();
        repeat (5) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_no_req: got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_no_out: got %b want 0", bus.out_valid); end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL redir_next_req_valid: got %b want 1", bus.imem_req_valid); end
        n_cmp++; if (bus.imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL redir_next_req_addr: got %h want 00000100", bus.imem_req_addr); end
        repeat (8) tick();
        n_cmp++; if (got_pc.size() < 3) begin n_bad++; $display("FAIL redir_pop_count: got %0d want >=3", got_pc.size()); end
        if (got_pc.size() >= 3) begin
            n_cmp++; if (got_pc[0] !== 32'h0) begin n_bad++; $display("FAIL redir_pop0: got %h want 0", got_pc[0]); end
            n_cmp++; if (got_pc[1] !== 32'h100) begin n_bad++; $display("FAIL redir_pop1: got %h want 00000100", got_pc[1]); end
            n_cmp++; if (got_instr[1] !== instr_of(32'h100)) begin n_bad++; $display("FAIL redir_instr1: got %h want %h", got_instr[1], instr_of(32'h100)); end
            n_cmp++; if (got_pc[2] !== 32'h104) begin n_bad++; $display("FAIL redir_pop2: got %h want 00000104", got_pc[2]); end
        end
    endtask

    task automatic test_random_redirect();
        logic [31:0] exp_pc;
        int          pops;
        mem_lat = 2;
        do_reset();
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 70; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = (i % 7 == 6);
            bus.redirect_pc    = 32'h203;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                n_cmp++; if (bus.out_pc !== exp_pc) begin n_bad++; $display("FAIL rand_pc cycle %0d: got %h want %h", i, bus.out_pc, exp_pc); end
                n_cmp++; if (bus.out_instr !== instr_of(exp_pc)) begin n_bad++; $display("FAIL rand_instr cycle %0d: got %h want %h", i, bus.out_instr, instr_of(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            if (bus.redirect_valid) exp_pc = 32'h200;
            tick();
        end
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        n_cmp++; if (max_inflight > DEPTH) begin n_bad++; $display("FAIL rand_inflight: got %0d want <=%0d", max_inflight, DEPTH); end
        n_cmp++; if (pops < 10) begin n_bad++; $display("FAIL rand_progress: got %0d pops want >=10", pops); end
    endtask

    task automatic test_wrap_and_reset();
        mem_lat = 1;
        do_reset();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_addr: got %h want fffffffc", bus.imem_req_addr); end
        n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_top_valid: got %b want 1", bus.imem_req_valid); end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next_addr: got %h want 0", bus.imem_req_addr); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_out_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_out_pc: got %h want fffffffc", bus.out_pc); end
        bus.imem_req_ready = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_req_valid: got %b want 0", bus.imem_req_valid); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_out_pc: got %h want 0", bus.out_pc); end
        n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL midrst_out_instr: got %h want 0", bus.out_instr); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL restart_addr: got %h want 0", bus.imem_req_addr); end
        repeat (2) tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL restart_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL restart_pc: got %h want 0", bus.out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_random_redirect();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
